wbxbc_rr_arbiter: RTL and testbench

- Shares one Wishbone pipelined target bus among N initiators, using round-robin arbitration per bus tenure (one CYC period).
- Sits in the crossbar fabric, one instance per target port, behind the SYSCON clock/reset.
- Supports LOCK: the owner keeps the bus across back-to-back cycles while it holds LOCK.
- Grants are registered; all other datapath muxing is combinational on the registered grant.

---
 rtl/wbxbc_arb_pkg.sv | 13 +
 rtl/wbxbc_rr_prio.sv | 41 ++++
 rtl/wbxbc_rr_arbiter.sv | 100 ++++++++++
 tb/tb_wbxbc_rr_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wbxbc_arb_pkg.sv
// Shared sizing helpers and types for the Wishbone crossbar round-robin arbiter.
package wbxbc_arb_pkg;

  localparam int unsigned MAX_N = 16;

  // Fixed-width working request vector; narrower arbiters zero-pad into it.
  typedef logic [MAX_N-1:0] req_vec_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wbxbc_rr_prio.sv
// Round-robin priority pick: first requester after 'last' in ascending order with wrap.
module wbxbc_rr_prio
  import wbxbc_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          any
);

  req_vec_t   req_pad;
  req_vec_t   pick_pad;
  logic [3:0] pos;
  logic       found;

  // Offsets 1..N visit last+1 first and the previous owner last.
  always_comb begin
    req_pad         = '0;
    req_pad[N-1:0]  = req;
    pick_pad        = '0;
    pick_idx        = '0;
    pos             = '0;
    found           = 1'b0;
    for (int off = 1; off <= N; off++) begin
      pos = 4'((int'(last) + off) % N);
      if (!found && req_pad[pos]) begin
        found         = 1'b1;
        pick_pad[pos] = 1'b1;
        pick_idx      = IW'(pos);
      end
    end
  end

  assign pick = pick_pad[N-1:0];
  assign any  = |req;

endmodule

// File: rtl/wbxbc_rr_arbiter.sv
// Round-robin Wishbone pipelined target-port arbiter with LOCK; grant is registered,
// the datapath is muxed combinationally on that grant.
module wbxbc_rr_arbiter
  import wbxbc_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  parameter int SEL_WIDTH = 2
) (
  input  logic                   clk_i,
  input  logic                   sync_rst_i,
  input  logic [N-1:0]           itr_cyc_i,
  input  logic [N-1:0]           itr_stb_i,
  input  logic [N-1:0]           itr_we_i,
  input  logic [N-1:0]           itr_lock_i,
  input  logic [N*ADR_WIDTH-1:0] itr_adr_i,
  input  logic [N*DAT_WIDTH-1:0] itr_dat_i,
  input  logic [N*SEL_WIDTH-1:0] itr_sel_i,
  output logic [N-1:0]           itr_ack_o,
  output logic [N-1:0]           itr_err_o,
  output logic [N-1:0]           itr_rty_o,
  output logic [N-1:0]           itr_stall_o,
  output logic [DAT_WIDTH-1:0]   itr_dat_o,
  output logic                   tgt_cyc_o,
  output logic                   tgt_stb_o,
  output logic                   tgt_we_o,
  output logic                   tgt_lock_o,
  output logic [ADR_WIDTH-1:0]   tgt_adr_o,
  output logic [DAT_WIDTH-1:0]   tgt_dat_o,
  output logic [SEL_WIDTH-1:0]   tgt_sel_o,
  input  logic                   tgt_ack_i,
  input  logic                   tgt_err_i,
  input  logic                   tgt_rty_i,
  input  logic                   tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]   tgt_dat_i,
  output logic [N-1:0]           gnt_o
);

  localparam int IW = idx_width(N);

  logic [N-1:0]  gnt_reg;
  logic [IW-1:0] last_reg;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          any;
  logic          hold;

  wbxbc_rr_prio #(.N(N), .IW(IW)) u_prio (
    .req      (itr_cyc_i),
    .last     (last_reg),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  // LOCK alone keeps the tenure, so a locked owner can re-raise CYC without arbitration.
  assign hold = |(gnt_reg & (itr_cyc_i | itr_lock_i));

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      gnt_reg  <= '0;
      last_reg <= IW'(N - 1);
    end else if (!hold) begin
      gnt_reg <= pick;
      if (any) begin
        last_reg <= pick_idx;
      end
    end
  end

  assign gnt_o = gnt_reg;

  assign tgt_cyc_o  = ~sync_rst_i & (|(gnt_reg & itr_cyc_i));
  assign tgt_stb_o  = ~sync_rst_i & (|(gnt_reg & itr_stb_i));
  assign tgt_lock_o = ~sync_rst_i & (|(gnt_reg & itr_lock_i));

  // One-hot grant makes an OR of masked slices a mux; idle yields all zeros.
  always_comb begin
    tgt_we_o  = 1'b0;
    tgt_adr_o = '0;
    tgt_dat_o = '0;
    tgt_sel_o = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_reg[k]) begin
        tgt_we_o  = tgt_we_o  | itr_we_i[k];
        tgt_adr_o = tgt_adr_o | itr_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
        tgt_dat_o = tgt_dat_o | itr_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
        tgt_sel_o = tgt_sel_o | itr_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  assign itr_ack_o   = sync_rst_i ? '0 : (gnt_reg & {N{tgt_ack_i}});
  assign itr_err_o   = sync_rst_i ? '0 : (gnt_reg & {N{tgt_err_i}});
  assign itr_rty_o   = sync_rst_i ? '0 : (gnt_reg & {N{tgt_rty_i}});
  assign itr_stall_o = ~gnt_reg | (gnt_reg & {N{tgt_stall_i}});
  assign itr_dat_o   = tgt_dat_i;

endmodule

// File: tb/tb_wbxbc_rr_arbiter.sv
// Directed bench for wbxbc_rr_arbiter (N=4): arbitration order, LOCK, routing, reset.
module tb_wbxbc_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cyc, stb, we, lock;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] wdat;
  logic [N*SW-1:0] sel;
  logic [N-1:0]    ack_o, err_o, rty_o, stall_o;
  logic [DW-1:0]   rdat_o;
  logic            t_cyc, t_stb, t_we, t_lock;
  logic [AW-1:0]   t_adr;
  logic [DW-1:0]   t_dat;
  logic [SW-1:0]   t_sel;
  logic            t_ack, t_err, t_rty, t_stall;
  logic [DW-1:0]   t_rdat;
  logic [N-1:0]    gnt;

  int n_cmp = 0;
  int n_err = 0;

  wbxbc_rr_arbiter #(.N(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk_i       (clk),
    .sync_rst_i  (rst),
    .itr_cyc_i   (cyc),
    .itr_stb_i   (stb),
    .itr_we_i    (we),
    .itr_lock_i  (lock),
    .itr_adr_i   (adr),
    .itr_dat_i   (wdat),
    .itr_sel_i   (sel),
    .itr_ack_o   (ack_o),
    .itr_err_o   (err_o),
    .itr_rty_o   (rty_o),
    .itr_stall_o (stall_o),
    .itr_dat_o   (rdat_o),
    .tgt_cyc_o   (t_cyc),
    .tgt_stb_o   (t_stb),
    .tgt_we_o    (t_we),
    .tgt_lock_o  (t_lock),
    .tgt_adr_o   (t_adr),
    .tgt_dat_o   (t_dat),
    .tgt_sel_o   (t_sel),
    .tgt_ack_i   (t_ack),
    .tgt_err_i   (t_err),
    .tgt_rty_i   (t_rty),
    .tgt_stall_i (t_stall),
    .tgt_dat_i   (t_rdat),
    .gnt_o       (gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks run 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      assert ($onehot0(gnt)) else begin
        n_err++;
        $error("FAIL onehot0 observed=%0h expected=onehot0", gnt);
      end
    end
  end

  initial begin
    rst = 1'b1; cyc = '0; stb = '0; we = '0; lock = '0;
    adr = '0; wdat = '0; sel = '0;
    t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; t_stall = 1'b0; t_rdat = '0;
    adr[0*AW +: AW] = 16'h1000; adr[1*AW +: AW] = 16'h1111;
    adr[2*AW +: AW] = 16'h2222; adr[3*AW +: AW] = 16'h3333;
    wdat[3*DW +: DW] = 16'hC0DE; sel[3*SW +: SW] = 2'b10;
    step(); step();
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_cyc", 32'(t_cyc), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'hF);

    // First request after reset goes to initiator 0 with one cycle of latency.
    rst = 1'b0; cyc = 4'b0001; stb = 4'b0001;
    #1;
    chk("lat_cyc_before", 32'(t_cyc), 32'h0);
    step(); #1;
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_cyc", 32'(t_cyc), 32'h1);
    chk("first_stb", 32'(t_stb), 32'h1);
    chk("first_adr", 32'(t_adr), 32'h1000);

    t_err = 1'b1; #1;
    chk("err_route", 32'(err_o), 32'h1);
    chk("err_no_ack", 32'(ack_o), 32'h0);
    chk("err_stall", 32'(stall_o), 32'hE);
    step(); t_err = 1'b0; cyc = '0; stb = '0;
    step();
    t_ack = 1'b1; #1;
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_stray_ack", 32'(ack_o), 32'h0);
    chk("idle_adr", 32'(t_adr), 32'h0);
    t_ack = 1'b0;

    // Fresh reset so the rotation starts at initiator 0.
    rst = 1'b1; step(); rst = 1'b0;
    cyc = 4'b1111;
    step();
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      logic [3:0] one;
      for (int i = 0; i < 5; i++) begin
        one = 4'b0001 << order[i];
        #1;
        chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(one));
        chk($sformatf("rr_cyc%0d", i), 32'(t_cyc), 32'h1);
        step(); step();
        cyc[order[i]] = 1'b0;
        step();
        cyc[order[i]] = 1'b1;
      end
    end
    #1;
    chk("rr_after", 32'(gnt), 32'h2);
    cyc = '0; stb = '0;
    step(); #1;
    chk("rr_idle", 32'(gnt), 32'h0);

    // LOCK: owner 2 keeps the bus with CYC low while 1 and 3 wait.
    cyc = 4'b0100; lock = 4'b0100;
    step(); #1;
    chk("lk_gnt", 32'(gnt), 32'h4);
    cyc = 4'b1010; #1;
    chk("lk_cyc_low", 32'(t_cyc), 32'h0);
    chk("lk_lock_out", 32'(t_lock), 32'h1);
    step(); #1;
    chk("lk_hold1", 32'(gnt), 32'h4);
    chk("lk_stall_waiters", 32'(stall_o), 32'hB);
    step(); #1;
    chk("lk_hold2", 32'(gnt), 32'h4);
    cyc = 4'b1110; stb = 4'b0100; t_ack = 1'b1; #1;
    chk("lk_recyc", 32'(t_cyc), 32'h1);
    chk("lk_adr", 32'(t_adr), 32'h2222);
    chk("lk_ack", 32'(ack_o), 32'h4);
    step(); t_ack = 1'b0; stb = '0; lock = '0; cyc = 4'b1010;
    step(); #1;
    chk("lk_next3", 32'(gnt), 32'h8);

    // Pipelined reads by owner 1 with a one-cycle target stall.
    cyc = 4'b0110;
    step(); #1;
    chk("pl_gnt", 32'(gnt), 32'h2);
    stb = 4'b0010; #1;
    chk("pl_stall0", 32'(stall_o), 32'hD);
    step(); t_stall = 1'b1; #1;
    chk("pl_stall1", 32'(stall_o), 32'hF);
    step(); t_stall = 1'b0; stb = '0; t_ack = 1'b1; t_rdat = 16'hBEEF; #1;
    chk("pl_stall_off", 32'(stall_o), 32'hD);
    chk("pl_ack1", 32'(ack_o), 32'h2);
    chk("pl_rdat", 32'(rdat_o), 32'hBEEF);
    step(); t_rdat = 16'h1234; #1;
    chk("pl_ack2", 32'(ack_o), 32'h2);
    chk("pl_rdat2", 32'(rdat_o), 32'h1234);
    step(); t_ack = 1'b0; cyc = 4'b0100;
    step(); #1;
    chk("pl_next2", 32'(gnt), 32'h4);

    // Reset pulse mid-transfer by owner 3.
    cyc = 4'b1000; stb = 4'b1000; we = 4'b1000;
    step(); #1;
    chk("rs_gnt", 32'(gnt), 32'h8);
    chk("rs_adr", 32'(t_adr), 32'h3333);
    chk("rs_dat", 32'(t_dat), 32'hC0DE);
    chk("rs_sel", 32'(t_sel), 32'h2);
    chk("rs_we", 32'(t_we), 32'h1);
    rst = 1'b1; t_ack = 1'b1; #1;
    chk("rs_cyc_gated", 32'(t_cyc), 32'h0);
    chk("rs_stb_gated", 32'(t_stb), 32'h0);
    chk("rs_ack_gated", 32'(ack_o), 32'h0);
    step(); rst = 1'b0; t_ack = 1'b0; #1;
    chk("rs_gnt_clear", 32'(gnt), 32'h0);
    chk("rs_cyc_idle", 32'(t_cyc), 32'h0);
    step(); #1;
    chk("rs_regain", 32'(gnt), 32'h8);
    chk("rs_regain_cyc", 32'(t_cyc), 32'h1);

    cyc = '0; stb = '0; we = '0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
